// File: rtl/fulladder_cell.sv
// One-bit full adder cell: sum and majority carry from a, b and carry-in.
// The top level chains WIDTH of these LSB to MSB.
module fulladder_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);

    // Sum is the three-way parity; carry is the majority of the three inputs.
    always_comb begin
        s_o    = a_i ^ b_i ^ cin_i;
        cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
    end

endmodule

// File: rtl/fulladder_behavioral.sv
// WIDTH-bit ripple-carry adder.
// Provides a same-cycle combinational result and a one-cycle registered copy of it.
module fulladder_behavioral #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_out_q
);

    // carry_s[i] is the carry into bit i; carry_s[WIDTH] leaves the MSB.
    logic [WIDTH:0] carry_s;

    assign carry_s[0] = carry_in;
    assign carry_out  = carry_s[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        fulladder_cell u_cell (
            .a_i    (a[i]),
            .b_i    (b[i]),
            .cin_i  (carry_s[i]),
            .s_o    (sum[i]),
            .cout_o (carry_s[i+1])
        );
    end

    // Output register stage. Reset clears only these flops, never the combinational path.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            carry_out_q <= 1'b0;
        end else begin
            sum_q       <= sum;
            carry_out_q <= carry_out;
        end
    end

endmodule

// File: tb/tb_fulladder_behavioral.sv
// Self-checking bench with a 1-bit and a 4-bit instance.
// An integer-arithmetic reference model is compared against both instances every cycle.
`timescale 1ns/1ps
module tb_fulladder_behavioral;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
    logic       s1, co1, sq1, coq1;
    logic [3:0] a4 = 4'h0, b4 = 4'h0;
    logic       cin4 = 1'b0;
    logic [3:0] s4, sq4;
    logic       co4, coq4;

    int errors = 0;
    int checks = 0;

    // Model state for the registered outputs.
    logic       q_valid = 1'b0;
    logic       cmp_comb_en = 1'b1;
    logic       exp_sq1, exp_coq1, exp_coq4;
    logic [3:0] exp_sq4;

    always #5 clk = ~clk;

    fulladder_behavioral #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .sum(s1), .carry_out(co1),
        .a(a1), .b(b1), .carry_in(cin1), .sum_q(sq1), .carry_out_q(coq1)
    );

    fulladder_behavioral #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .sum(s4), .carry_out(co4),
        .a(a4), .b(b4), .carry_in(cin4), .sum_q(sq4), .carry_out_q(coq4)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int total1();
        return int'(a1) + int'(b1) + int'(cin1);
    endfunction

    function automatic int total4();
        return int'(a4) + int'(b4) + int'(cin4);
    endfunction

    // Reference model of the register stage: the arithmetic total seen at each rising edge.
    always @(posedge clk) begin
        q_valid <= 1'b1;
        if (rst) begin
            exp_sq1 <= 1'b0; exp_coq1 <= 1'b0;
            exp_sq4 <= 4'h0; exp_coq4 <= 1'b0;
        end else begin
            exp_sq1  <= 1'((total1() % 2));
            exp_coq1 <= 1'((total1() / 2));
            exp_sq4  <= 4'((total4() % 16));
            exp_coq4 <= 1'((total4() / 16));
        end
    end

    // Per-cycle comparison of both instances against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_comb_en) begin
            chk("w1_sum",  {7'b0, s1},  8'(total1() % 2));
            chk("w1_cout", {7'b0, co1}, 8'(total1() / 2));
            chk("w4_sum",  {4'b0, s4},  8'(total4() % 16));
            chk("w4_cout", {7'b0, co4}, 8'(total4() / 16));
        end
        if (q_valid) begin
            chk("w1_sum_q",  {7'b0, sq1},  {7'b0, exp_sq1});
            chk("w1_cout_q", {7'b0, coq1}, {7'b0, exp_coq1});
            chk("w4_sum_q",  {4'b0, sq4},  {4'b0, exp_sq4});
            chk("w4_cout_q", {7'b0, coq4}, {7'b0, exp_coq4});
        end
    end

    logic [2:0] vec_tbl [8];
    logic [1:0] res_tbl [8];

    initial begin
        // {a,b,cin} and expected {sum,cout}, worked by hand from the truth table.
        vec_tbl[0] = 3'b000; res_tbl[0] = 2'b00;
        vec_tbl[1] = 3'b100; res_tbl[1] = 2'b10;
        vec_tbl[2] = 3'b010; res_tbl[2] = 2'b10;
        vec_tbl[3] = 3'b110; res_tbl[3] = 2'b01;
        vec_tbl[4] = 3'b001; res_tbl[4] = 2'b10;
        vec_tbl[5] = 3'b101; res_tbl[5] = 2'b01;
        vec_tbl[6] = 3'b011; res_tbl[6] = 2'b01;
        vec_tbl[7] = 3'b111; res_tbl[7] = 2'b11;

        @(posedge clk); #2;
        chk("reset_sum_q",  {7'b0, sq1},  8'h00);
        chk("reset_cout_q", {7'b0, coq1}, 8'h00);
        chk("reset_sum4_q", {4'b0, sq4},  8'h00);
        rst = 1'b0;

        // Exhaustive 1-bit table, one time unit apart, clear of both clock edges' checks.
        @(posedge clk);
        cmp_comb_en = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            {a1, b1, cin1} = vec_tbl[i];
            #1;
            chk("truth_sum",  {7'b0, s1},  {7'b0, res_tbl[i][1]});
            chk("truth_cout", {7'b0, co1}, {7'b0, res_tbl[i][0]});
        end
        @(posedge clk); #2;
        cmp_comb_en = 1'b1;

        // Latency: 0,0,0 registered, then 1,1,1 held until the following edge.
        {a1, b1, cin1} = 3'b000;
        @(posedge clk); #2;
        {a1, b1, cin1} = 3'b111;
        #3;
        chk("latency_hold_sum_q",  {7'b0, sq1},  8'h00);
        chk("latency_hold_cout_q", {7'b0, coq1}, 8'h00);
        @(posedge clk); #1;
        chk("latency_sum_q",  {7'b0, sq1},  8'h01);
        chk("latency_cout_q", {7'b0, coq1}, 8'h01);

        // Reset for one edge with 1,1,0.
        #1;
        rst = 1'b1; {a1, b1, cin1} = 3'b110;
        @(posedge clk); #1;
        chk("rst_sum_q",  {7'b0, sq1},  8'h00);
        chk("rst_cout_q", {7'b0, coq1}, 8'h00);
        chk("rst_sum",    {7'b0, s1},   8'h00);
        chk("rst_cout",   {7'b0, co1},  8'h01);

        // Release reset with 0,1,1.
        #1;
        rst = 1'b0; {a1, b1, cin1} = 3'b011;
        @(posedge clk); #1;
        chk("release_sum_q",  {7'b0, sq1},  8'h00);
        chk("release_cout_q", {7'b0, coq1}, 8'h01);

        // 4-bit wrap corners.
        #1;
        a4 = 4'hF; b4 = 4'h0; cin4 = 1'b1;
        #1;
        chk("wrap_f0_sum",  {4'b0, s4},  8'h00);
        chk("wrap_f0_cout", {7'b0, co4}, 8'h01);
        a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
        #1;
        chk("wrap_ff_sum",  {4'b0, s4},  8'h0F);
        chk("wrap_ff_cout", {7'b0, co4}, 8'h01);
        @(posedge clk); #1;
        chk("wrap_ff_sum_q",  {4'b0, sq4},  8'h0F);
        chk("wrap_ff_cout_q", {7'b0, coq4}, 8'h01);

        // Random vectors; the per-cycle compare process checks both paths.
        for (int n = 0; n < 1000; n++) begin
            @(posedge clk); #2;
            a4   = 4'($urandom_range(15, 0));
            b4   = 4'($urandom_range(15, 0));
            cin4 = 1'($urandom_range(1, 0));
            a1   = 1'($urandom_range(1, 0));
            b1   = 1'($urandom_range(1, 0));
            cin1 = 1'($urandom_range(1, 0));
            if (n % 97 == 50) rst = 1'b1;
            else              rst = 1'b0;
        end
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
